// File: rtl/seq_adder_pkg.sv
// Shared definitions for the multi-cycle sliced add/subtract unit.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Slice counter needs at least one bit even when a single slice covers the word.
  function automatic int cnt_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/seq_adder_slice.sv
// Combinational ripple-carry slice; also exposes the carry into its top bit for overflow.
module seq_adder_slice #(
  parameter int SLICE = 4
) (
  output logic [SLICE-1:0] S,
  output logic             Cout,
  output logic             c_msb,
  input  logic [SLICE-1:0] A,
  input  logic [SLICE-1:0] B,
  input  logic             Cin
);

  logic [SLICE:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout  = c[SLICE];
  assign c_msb = c[SLICE-1];

endmodule

// File: rtl/seq_adder.sv
// Multi-cycle add/subtract: one SLICE-wide ripple slice reused LSB-first, carry held
// in a register between slices, with start/busy/done handshake and overflow flag.
module seq_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = cnt_width(NSLICE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic             last_slice;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_s;
  logic             slice_cout;
  logic             slice_cmsb;

  assign accept     = start && (state_q != RUN);
  assign last_slice = (state_q == RUN) && (cnt_q == LAST);

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // ---- operand capture (B is pre-inverted for subtract) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0 <= A;
      b_p0 <= (mode == MODE_SUB) ? ~B : B;
    end
  end

  always_comb begin
    slice_a = a_p0[cnt_q*SLICE +: SLICE];
    slice_b = b_p0[cnt_q*SLICE +: SLICE];
  end

  seq_adder_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .S     (slice_s),
    .Cout  (slice_cout),
    .c_msb (slice_cmsb),
    .A     (slice_a),
    .B     (slice_b),
    .Cin   (carry_q)
  );

  // ---- slice accumulation; results only move while running ----
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q <= 1'b0;
      cnt_q   <= '0;
      S       <= '0;
      Cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      carry_q <= (mode == MODE_ADD) ? Cin : 1'b1;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      S[cnt_q*SLICE +: SLICE] <= slice_s;
      carry_q                 <= slice_cout;
      if (cnt_q != LAST) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (last_slice) begin
        Cout <= slice_cout;
        ovf  <= slice_cmsb ^ slice_cout;
      end
    end
  end

endmodule

// File: tb/tb_seq_adder.sv
// Scoreboarded random/directed bench for seq_adder in a 16/4 and an 8/8 configuration.
module tb_seq_adder;

  localparam int N0 = 4;
  localparam int N1 = 1;

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  logic        reset0, start0, mode0, cin0;
  logic [15:0] a0, b0;
  logic        busy0, done0, cout0, ovf0;
  logic [15:0] s0;

  logic        reset1, start1, mode1, cin1;
  logic [7:0]  a1, b1;
  logic        busy1, done1, cout1, ovf1;
  logic [7:0]  s1;

  exp_t        q0[$];
  exp_t        q1[$];
  int          last_acc0 = -1000;
  int          last_acc1 = -1000;
  logic [15:0] held_s0 = '0;
  logic        held_c0 = 1'b0, held_o0 = 1'b0;
  logic [7:0]  held_s1 = '0;
  logic        held_c1 = 1'b0, held_o1 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_adder #(.WIDTH(16), .SLICE(4)) dut0 (
    .clk(clk), .reset(reset0), .start(start0), .mode(mode0), .A(a0), .B(b0), .Cin(cin0),
    .busy(busy0), .done(done0), .S(s0), .Cout(cout0), .ovf(ovf0)
  );

  seq_adder #(.WIDTH(8), .SLICE(8)) dut1 (
    .clk(clk), .reset(reset1), .start(start1), .mode(mode1), .A(a1), .B(b1), .Cin(cin1),
    .busy(busy1), .done(done1), .S(s1), .Cout(cout1), .ovf(ovf1)
  );

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(int w, logic m, logic [15:0] a, logic [15:0] b, logic cin, int acc);
    exp_t e;
    int mask = (1 << w) - 1;
    int half = 1 << (w - 1);
    int ua = int'(a) & mask;
    int ub = int'(b) & mask;
    int sa = (ua >= half) ? ua - (1 << w) : ua;
    int sb = (ub >= half) ? ub - (1 << w) : ub;
    int full, sres;
    if (m) begin
      full   = (ua - ub) & mask;
      e.cout = (ua >= ub);
      sres   = sa - sb;
    end else begin
      full   = ua + ub + int'(cin);
      e.cout = ((full >> w) & 1) != 0;
      sres   = sa + sb + int'(cin);
    end
    e.s   = 16'(full & mask);
    e.ovf = (sres >= half) || (sres < -half);
    e.acc = acc;
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Monitors: sample 1 time unit after each rising edge.
  always begin
    int d;
    exp_t e;
    @(posedge clk);
    #1;
    d = cyc - last_acc0;
    chk("busy0", 32'(busy0), 32'(d >= 0 && d < N0));
    chk("done0", 32'(done0), 32'(d == N0));
    if (done0) begin
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done0_unexpected cyc=%0d actual=done required=no_done", cyc);
      end else begin
        e = q0.pop_front();
        chk("S0", 32'(s0), 32'(e.s));
        chk("Cout0", 32'(cout0), 32'(e.cout));
        chk("ovf0", 32'(ovf0), 32'(e.ovf));
        chk("latency0", cyc - e.acc, N0);
        held_s0 = e.s; held_c0 = e.cout; held_o0 = e.ovf;
      end
    end else if (!busy0) begin
      chk("hold_S0", 32'(s0), 32'(held_s0));
      chk("hold_Cout0", 32'(cout0), 32'(held_c0));
      chk("hold_ovf0", 32'(ovf0), 32'(held_o0));
    end
  end

  always begin
    int d;
    exp_t e;
    @(posedge clk);
    #1;
    d = cyc - last_acc1;
    chk("busy1", 32'(busy1), 32'(d >= 0 && d < N1));
    chk("done1", 32'(done1), 32'(d == N1));
    if (done1) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done1_unexpected cyc=%0d actual=done required=no_done", cyc);
      end else begin
        e = q1.pop_front();
        chk("S1", 32'(s1), 32'(e.s[7:0]));
        chk("Cout1", 32'(cout1), 32'(e.cout));
        chk("ovf1", 32'(ovf1), 32'(e.ovf));
        chk("latency1", cyc - e.acc, N1);
        held_s1 = e.s[7:0]; held_c1 = e.cout; held_o1 = e.ovf;
      end
    end else if (!busy1) begin
      chk("hold_S1", 32'(s1), 32'(held_s1));
      chk("hold_Cout1", 32'(cout1), 32'(held_c1));
      chk("hold_ovf1", 32'(ovf1), 32'(held_o1));
    end
  end

  // Issue one op; operands are scrambled while it runs, and a stray start is pulsed
  // in busy cycle 1 (non-hold) or start stays high throughout (hold).
  task automatic op0(logic m, logic [15:0] a, logic [15:0] b, logic cin, bit hold);
    @(negedge clk);
    mode0 = m; a0 = a; b0 = b; cin0 = cin; start0 = 1'b1;
    last_acc0 = cyc + 1;
    q0.push_back(model(16, m, a, b, cin, cyc + 1));
    for (int k = 0; k < N0; k++) begin
      @(negedge clk);
      a0 = 16'($urandom); b0 = 16'($urandom); cin0 = 1'($urandom); mode0 = 1'($urandom);
      if (!hold) start0 = (k == 1);
    end
  endtask

  task automatic idle0(int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start0 = 1'b0; a0 = 16'($urandom); b0 = 16'($urandom);
    end
  endtask

  task automatic op1(logic m, logic [7:0] a, logic [7:0] b, logic cin, bit hold);
    @(negedge clk);
    mode1 = m; a1 = a; b1 = b; cin1 = cin; start1 = 1'b1;
    last_acc1 = cyc + 1;
    q1.push_back(model(8, m, {8'h00, a}, {8'h00, b}, cin, cyc + 1));
    for (int k = 0; k < N1; k++) begin
      @(negedge clk);
      a1 = 8'($urandom); b1 = 8'($urandom); cin1 = 1'($urandom); mode1 = 1'($urandom);
      if (!hold) start1 = 1'b0;
    end
  endtask

  task automatic idle1(int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start1 = 1'b0;
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset0 = 1'b1; start0 = 1'b0; mode0 = 1'b0; cin0 = 1'b0; a0 = '0; b0 = '0;
    reset1 = 1'b1; start1 = 1'b0; mode1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    reset0 = 1'b0; reset1 = 1'b0;
    idle0(1);

    op0(1'b0, 16'h1234, 16'h1111, 1'b0, 1'b0);
    op0(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    op0(1'b0, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
    op0(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b0);
    op0(1'b1, 16'h8000, 16'h0001, 1'b1, 1'b0);
    idle0(2);

    // Reset in RUN cycle 2, then a fresh op.
    @(negedge clk);
    mode0 = 1'b0; a0 = 16'hAAAA; b0 = 16'h5555; cin0 = 1'b0; start0 = 1'b1;
    last_acc0 = cyc + 1;
    @(negedge clk); start0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset0 = 1'b1; last_acc0 = -1000; held_s0 = '0; held_c0 = 1'b0; held_o0 = 1'b0;
    @(negedge clk);
    reset0 = 1'b0;
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_done0", 32'(done0), 0);
    chk("rst_S0", 32'(s0), 0);
    chk("rst_Cout0", 32'(cout0), 0);
    chk("rst_ovf0", 32'(ovf0), 0);
    op0(1'b0, 16'h1234, 16'h1111, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++)
      op0(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
    idle0(1);

    for (int i = 0; i < 30; i++) begin
      op0(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle0($urandom_range(1, 3));
    end
    idle0(N0 + 2);

    op1(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0);
    op1(1'b0, 8'h7F, 8'h00, 1'b1, 1'b0);
    idle1(1);
    op1(1'b1, 8'h00, 8'h01, 1'b0, 1'b0);
    op1(1'b1, 8'h80, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++)
      op1(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    idle1(N1 + 3);

    chk("pending0", q0.size(), 0);
    chk("pending1", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
